// File: rtl/dmem_bridge.sv
// Data-memory bridge: posted write buffer, load FSM and byte-lane alignment toward a word-wide req/ack memory.
// Optional store-to-load forwarding is compiled in with `define DMEM_BRIDGE_FWD_EN.
module dmem_bridge #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_oe,
    input  logic [3:0]        mem_we,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_valid,
    output logic              mem_ready,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-3:0] ext_addr,
    output logic [3:0]        ext_be,
    output logic [31:0]       ext_wdata,
    input  logic              ext_ack,
    input  logic [31:0]       ext_rdata,
    output logic              misalign
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(WB_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LREQ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    logic            req, bad_align, is_store, is_load, mis_load, load_acc;
    logic [3:0]      strobe;
    logic [1:0]      shift;
    logic [WA_W-1:0] req_waddr;
    logic [3:0]      req_be;
    logic [31:0]     req_wdata, req_mask;

    // Core side: mem_ready high in cycle N means a request (mem_oe != 0) in cycle N+1 is taken;
    // ext side: ext_req with stable fields is held until the one-cycle ext_ack completes it.
    assign req       = |mem_oe;
    assign strobe    = (|mem_we) ? mem_we : mem_oe;
    assign shift     = mem_addr[1:0];
    assign bad_align = (strobe[1] && mem_addr[0]) ||
                       ((strobe[2] || strobe[3]) && (mem_addr[1:0] != 2'b00));
    assign is_store  = req && (|mem_we) && !bad_align;
    assign is_load   = req && !(|mem_we) && !bad_align;
    assign mis_load  = req && !(|mem_we) && bad_align;
    assign load_acc  = is_load && (state == ST_IDLE);
    assign req_waddr = mem_addr[ADDR_W-1:2];
    assign req_be    = strobe << shift;
    assign req_wdata = mem_wdata << {shift, 3'b000};
    assign req_mask  = {{8{strobe[3]}}, {8{strobe[2]}}, {8{strobe[1]}}, {8{strobe[0]}}};

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    logic [WA_W-1:0]  fifo_addr [WB_DEPTH];
    logic [3:0]       fifo_be   [WB_DEPTH];
    logic [31:0]      fifo_data [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic             fifo_empty, wr_active, push, pop;

    assign fifo_empty = (count == '0);
    assign wr_active  = !fifo_empty && (state != ST_LREQ);
    assign push       = is_store;
    assign pop        = wr_active && ext_ack;
    assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_waddr;
            fifo_be[wr_ptr]   <= req_be;
            fifo_data[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Store-to-load forwarding lookup
    // ------------------------------------------------------------------
    logic        fwd_hit;
    logic [31:0] fwd_data;

`ifdef DMEM_BRIDGE_FWD_EN
    logic             m_found;
    logic [3:0]       m_be;
    logic [31:0]      m_data;
    logic [PTR_W-1:0] m_idx;

    // Walk oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        m_found = 1'b0;
        m_be    = '0;
        m_data  = '0;
        m_idx   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            m_idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (fifo_addr[m_idx] == req_waddr)) begin
                m_found = 1'b1;
                m_be    = fifo_be[m_idx];
                m_data  = fifo_data[m_idx];
            end
        end
        fwd_hit  = m_found && ((m_be & req_be) == req_be);
        fwd_data = (m_data >> {shift, 3'b000}) & req_mask;
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // ------------------------------------------------------------------
    // Load FSM: state register, next state, outputs
    // ------------------------------------------------------------------
    logic [WA_W-1:0] ld_waddr;
    logic [3:0]      ld_be;
    logic [1:0]      ld_shift;
    logic [31:0]     ld_mask, ld_fwd_data;
    logic            ld_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load_acc) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (ld_fwd)          state_next = ST_RESP;
                else if (fifo_empty) state_next = ST_LREQ;
            end
            ST_LREQ:  if (ext_ack) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    logic mis_valid;

    always_comb begin
        ext_req   = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_be    = '0;
        ext_wdata = '0;
        if (state == ST_LREQ) begin
            ext_req  = 1'b1;
            ext_addr = ld_waddr;
            ext_be   = ld_be;
        end else if (!fifo_empty) begin
            ext_req   = 1'b1;
            ext_we    = 1'b1;
            ext_addr  = fifo_addr[rd_ptr];
            ext_be    = fifo_be[rd_ptr];
            ext_wdata = fifo_data[rd_ptr];
        end
        mem_valid = (state == ST_RESP) || mis_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_waddr    <= '0;
            ld_be       <= '0;
            ld_shift    <= '0;
            ld_mask     <= '0;
            ld_fwd      <= 1'b0;
            ld_fwd_data <= '0;
        end else if (load_acc) begin
            ld_waddr    <= req_waddr;
            ld_be       <= req_be;
            ld_shift    <= shift;
            ld_mask     <= req_mask;
            ld_fwd      <= fwd_hit;
            ld_fwd_data <= fwd_data;
        end
    end

    // ------------------------------------------------------------------
    // Core-facing response, ready and sticky error
    // ------------------------------------------------------------------
    logic [31:0] rdata_q;
    logic        ready_q, misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            mis_valid  <= 1'b0;
            ready_q    <= 1'b1;
            misalign_q <= 1'b0;
        end else begin
            if ((state == ST_LREQ) && ext_ack)
                rdata_q <= (ext_rdata >> {ld_shift, 3'b000}) & ld_mask;
            else if ((state == ST_DRAIN) && ld_fwd)
                rdata_q <= ld_fwd_data;
            else if (mis_load)
                rdata_q <= '0;
            // A dropped load still owes the core a response so it cannot hang.
            mis_valid  <= mis_load;
            ready_q    <= (count_next < DEPTH_C) && (state_next == ST_IDLE) &&
                          !load_acc && !mis_load;
            misalign_q <= misalign_q || (req && bad_align);
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: core-side driver, ext memory responder, scoreboard queues.
// Exercises the forwarding path when compiled with DMEM_BRIDGE_FWD_EN.
module tb_dmem_bridge;

    logic        clk, rst_n;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ext_wdata, ext_rdata;
    logic [3:0]  mem_oe, mem_we, ext_be;
    logic        mem_valid, mem_ready, ext_req, ext_we, ext_ack, misalign;
    logic [29:0] ext_addr;

    dmem_bridge #(.WB_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_be(ext_be),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .misalign(misalign)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [66:0] ext_q[$];   // {we, word addr, be, wdata}
    logic [31:0] exp_q[$];   // load data
    int          lat_q[$];   // expected latency, -1 = unchecked
    int          acc_q[$];   // request cycle
    logic [31:0] arch_mem [256];
    logic [31:0] resp_mem [256];
    int          req_cyc;
    int          ack_lat = 0;
    int          ack_budget = -1;
    int          wait_cnt = 0;
    logic [31:0] mon_exp;
    int          mon_lat, mon_acc;
    logic [31:0] rnd_addr;
    logic [3:0]  rnd_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic is_bad(input logic [31:0] addr, input logic [3:0] s);
        return (s[1] && addr[0]) || ((s[2] || s[3]) && (addr[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [31:0] addr, input logic [3:0] oe,
                             input logic [3:0] we, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!mem_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ready) check("ready_timeout", 32'(mem_ready), 32'd1);
        @(posedge clk); #1;
        mem_addr = addr; mem_oe = oe; mem_we = we; mem_wdata = wdata;
        req_cyc = cyc;
        @(posedge clk); #1;
        mem_oe = '0; mem_we = '0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [3:0] s, input logic [31:0] d);
        logic [3:0]  be;
        logic [31:0] wd;
        if (!is_bad(addr, s)) begin
            be = s << addr[1:0];
            wd = d << {addr[1:0], 3'b000};
            ext_q.push_back({1'b1, addr[31:2], be, wd});
            for (int k = 0; k < 4; k++)
                if (be[k]) arch_mem[addr[9:2]][k*8 +: 8] = wd[k*8 +: 8];
        end
        drive_req(addr, s, s, d);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] s, input int lat, input bit fwd);
        logic [3:0] be;
        if (is_bad(addr, s)) begin
            exp_q.push_back(32'h0);
            lat_q.push_back(1);
        end else begin
            be = s << addr[1:0];
            exp_q.push_back((arch_mem[addr[9:2]] >> {addr[1:0], 3'b000}) & lane_mask(s));
            lat_q.push_back(lat);
            if (!fwd) ext_q.push_back({1'b0, addr[31:2], be, 32'h0});
        end
        drive_req(addr, s, 4'b0000, 32'h0);
        acc_q.push_back(req_cyc);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ext_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'(ext_q.size() + exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- external memory responder ----------------
    task automatic check_ext();
        logic [66:0] e;
        logic [7:0]  w;
        w = ext_addr[7:0];
        if (ext_we) begin
            for (int k = 0; k < 4; k++)
                if (ext_be[k]) resp_mem[w][k*8 +: 8] = ext_wdata[k*8 +: 8];
        end else begin
            ext_rdata = resp_mem[w];
        end
        if (ext_q.size() == 0) begin
            check("ext_unexpected", 32'(ext_req), 32'd0);
        end else begin
            e = ext_q.pop_front();
            check("ext_we", 32'(ext_we), 32'(e[66]));
            check("ext_addr", 32'(ext_addr), 32'(e[65:36]));
            check("ext_be", 32'(ext_be), 32'(e[35:32]));
            if (e[66]) check("ext_wdata", ext_wdata, e[31:0]);
        end
    endtask

    initial begin
        ext_ack = 1'b0;
        ext_rdata = '0;
        forever begin
            @(posedge clk); #1;
            ext_ack = 1'b0;
            if (!rst_n || !ext_req) begin
                wait_cnt = 0;
            end else if (ack_budget != 0) begin
                if (wait_cnt >= ack_lat) begin
                    check_ext();
                    ext_ack = 1'b1;
                    wait_cnt = 0;
                    if (ack_budget > 0) ack_budget--;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && mem_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                check("valid_unexpected", 32'(mem_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_lat = lat_q.pop_front();
                mon_acc = acc_q.pop_front();
                check("load_data", mem_rdata, mon_exp);
                if (mon_lat >= 0) check("load_latency", 32'(cyc - mon_acc), 32'(mon_lat));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        mem_addr = '0; mem_oe = '0; mem_we = '0; mem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            arch_mem[i] = '0;
            resp_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ext_req", 32'(ext_req), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        rst_n = 1'b1;

        // Byte store at lane 3, then byte load back through the ext read path.
        ack_lat = 0;
        do_store(32'h0000_0103, 4'b0001, 32'h0000_00AB);
        do_load(32'h0000_0103, 4'b0001, 3, 1'b0);
        wait_idle();

        // Fill the buffer with ack held low, then release a single ack.
        ack_budget = 0;
        for (int i = 0; i < 4; i++)
            do_store(32'h0000_0040 + 32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i));
        @(negedge clk);
        check("full_ready", 32'(mem_ready), 32'd0);
        ack_budget = 1;
        n = 0;
        while (!ext_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("single_ack_seen", 32'(ext_ack), 32'd1);
        check("ready_in_ack_cycle", 32'(mem_ready), 32'd0);
        @(negedge clk);
        check("ready_after_pop", 32'(mem_ready), 32'd1);
        ack_budget = -1;
        wait_idle();

        // Word store then load of the same word with slow acks.
        ack_lat = 2;
        do_store(32'h0000_0200, 4'b1111, 32'h1122_3344);
        do_load(32'h0000_0200, 4'b1111, -1, 1'b0);
        wait_idle();
        ack_lat = 0;

        // Misaligned half load and word store are dropped.
        do_load(32'h0000_0201, 4'b0011, 1, 1'b0);
        @(negedge clk);
        check("misalign_set", 32'(misalign), 32'd1);
        check("misalign_no_req", 32'(ext_req), 32'd0);
        do_store(32'h0000_0102, 4'b1111, 32'h5555_5555);
        wait_idle();

        // Load hitting a buffered store while ext acks are held off.
        ack_budget = 0;
        do_store(32'h0000_0300, 4'b1111, 32'hDEAD_BEEF);
`ifdef DMEM_BRIDGE_FWD_EN
        do_load(32'h0000_0302, 4'b0011, 2, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fwd_load_done", 32'(exp_q.size()), 32'd0);
        check("fwd_write_pending", 32'(ext_q.size()), 32'd1);
`else
        do_load(32'h0000_0302, 4'b0011, -1, 1'b0);
        repeat (8) @(negedge clk);
        check("load_waits_drain", 32'(exp_q.size()), 32'd1);
`endif
        ack_budget = -1;
        wait_idle();

        // Random aligned and misaligned traffic over a small window.
        for (int i = 0; i < 24; i++) begin
            rnd_addr = 32'h0000_0080 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       rnd_s = 4'b0001;
                1:       rnd_s = 4'b0011;
                default: rnd_s = 4'b1111;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                do_store(rnd_addr, rnd_s, $urandom);
                repeat (2) @(posedge clk);
            end else begin
                do_load(rnd_addr, rnd_s, 3, 1'b0);
            end
        end
        wait_idle();
        check("ext_q_empty", 32'(ext_q.size()), 32'd0);
        check("load_q_empty", 32'(exp_q.size()), 32'd0);
        check("misalign_sticky", 32'(misalign), 32'd1);

        // Reset while the buffer is mid-drain.
        ack_budget = 0;
        do_store(32'h0000_01C0, 4'b1111, 32'h0101_0101);
        do_store(32'h0000_01C4, 4'b1111, 32'h0202_0202);
        do_store(32'h0000_01C8, 4'b1111, 32'h0303_0303);
        @(negedge clk);
        check("drain_req_held", 32'(ext_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ext_req", 32'(ext_req), 32'd0);
        check("async_rst_ready", 32'(mem_ready), 32'd1);
        check("async_rst_misalign", 32'(misalign), 32'd0);
        check("async_rst_valid", 32'(mem_valid), 32'd0);
        ext_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_budget = -1;
        repeat (10) @(negedge clk);
        check("post_rst_no_req", 32'(ext_req), 32'd0);
        check("post_rst_ready", 32'(mem_ready), 32'd1);
        check("post_rst_rdata", mem_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
